// File: rtl/aes_pipe_arbiter_pkg.sv
// AES definitions shared by the two-requester pipeline arbiter: block/key types,
// requester tags carried alongside the pipeline, and the round-robin pick.
package aes_pipe_arbiter_pkg;

  typedef logic [127:0] state_t;
  typedef logic [127:0] key_t;

  localparam int NUM_REQ = 2;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } pipe_tag_t;

  // A tie goes to the requester that was not granted last.
  function automatic req_id_t rr_pick(input logic [NUM_REQ-1:0] elig, input req_id_t last);
    req_id_t pick;
    if (elig == 2'b11) pick = ~last;
    else if (elig[1])  pick = 1'b1;
    else               pick = 1'b0;
    return pick;
  endfunction

endpackage

// File: rtl/aes_pipe_arbiter_resp_fifo.sv
// First-word-fall-through 128-bit response FIFO with an occupancy count.
// Push and pop in the same cycle are legal at any occupancy.
module aes_resp_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [127:0]               push_data,
  input  logic                       pop,
  output logic [127:0]               head,
  output logic                       not_empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_pipe_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable AES pipeline between two
// requesters. Optional AES_ARB_STATS_EN adds per-requester issue/stall counters.
module aes_pipe_arbiter
  import aes_pipe_arbiter_pkg::*;
#(
  parameter int LATENCY   = 11,
  parameter int OUT_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  state_t [NUM_REQ-1:0]        req_data,
  input  key_t [NUM_REQ-1:0]          req_key,
  output state_t                      pipe_in,
  output key_t                        pipe_key,
  input  state_t                      pipe_out,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output state_t [NUM_REQ-1:0]        resp_data
`ifdef AES_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0]    issue_count,
  output logic [NUM_REQ-1:0][31:0]    stall_count
`endif
);

  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic [CW-1:0]      fifo_count [NUM_REQ];
  logic [CW-1:0]      inflight   [NUM_REQ];
  logic [CW-1:0]      credit     [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic               any_grant;
  req_id_t            grant_id;
  req_id_t            last_id;
  pipe_tag_t          tag_sr [LATENCY+1];

  // Handshake: a request moves on a rising edge where req_valid & req_ready;
  // a response moves where resp_valid & resp_ready. req_ready is combinational
  // and one-hot, never asserted while reset is held low.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      credit[i] = CW'(OUT_DEPTH) - fifo_count[i] - inflight[i];
      elig[i]   = req_valid[i] && (credit[i] != '0);
    end
    grant_id = rr_pick(elig, last_id);
    if (reset && (elig != '0)) grant[grant_id] = 1'b1;
  end

  assign req_ready = grant;
  assign any_grant = |grant;
  assign pop       = resp_valid & resp_ready;

  // Tag stage k lines up with the block k cycles after issue; the last stage
  // marks the cycle its result is on pipe_out.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      push[i] = tag_sr[LATENCY].valid && (tag_sr[LATENCY].id == req_id_t'(i));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s <= LATENCY; s++) tag_sr[s] <= '0;
      pipe_in  <= '0;
      pipe_key <= '0;
      last_id  <= 1'b1;
    end else begin
      tag_sr[0] <= '{valid: any_grant, id: grant_id};
      for (int s = 1; s <= LATENCY; s++) tag_sr[s] <= tag_sr[s-1];
      if (any_grant) begin
        pipe_in  <= req_data[grant_id];
        pipe_key <= req_key[grant_id];
        last_id  <= grant_id;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) inflight[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({grant[i], push[i]})
          2'b10:   inflight[i] <= inflight[i] + CW'(1);
          2'b01:   inflight[i] <= inflight[i] - CW'(1);
          default: inflight[i] <= inflight[i];
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    aes_resp_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push[g]),
      .push_data (pipe_out),
      .pop       (pop[g]),
      .head      (resp_data[g]),
      .not_empty (resp_valid[g]),
      .count     (fifo_count[g])
    );
  end

`ifdef AES_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      issue_count <= '0;
      stall_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) issue_count[i] <= issue_count[i] + 32'd1;
        if (req_valid[i] && !req_ready[i]) stall_count[i] <= stall_count[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aes_pipe_arbiter.sv
// Directed bench for aes_pipe_arbiter with a behavioural XOR pipeline model and
// a per-requester expected-response scoreboard.
module tb_aes_pipe_arbiter;
  import aes_pipe_arbiter_pkg::*;

  localparam int LATENCY   = 11;
  localparam int OUT_DEPTH = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  state_t [1:0] req_data;
  key_t [1:0]   req_key;
  state_t       pipe_in;
  key_t         pipe_key;
  state_t       pipe_out;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  state_t [1:0] resp_data;
`ifdef AES_ARB_STATS_EN
  logic [1:0][31:0] issue_count;
  logic [1:0][31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;
  int acc_cnt [2] = '{0, 0};
  int rx_cnt [2] = '{0, 0};
  int outstanding [2] = '{0, 0};
  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];
  state_t pipe_sr [LATENCY];

  always #5 clock = ~clock;

  aes_pipe_arbiter #(.LATENCY(LATENCY), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_key    (req_key),
    .pipe_in    (pipe_in),
    .pipe_key   (pipe_key),
    .pipe_out   (pipe_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
`ifdef AES_ARB_STATS_EN
    ,
    .issue_count(issue_count),
    .stall_count(stall_count)
`endif
  );

  // Stand-in cipher: LATENCY register stages computing block ^ key.
  always @(posedge clock) begin
    pipe_sr[0] <= pipe_in ^ pipe_key;
    for (int s = 1; s < LATENCY; s++) pipe_sr[s] <= pipe_sr[s-1];
  end
  assign pipe_out = pipe_sr[LATENCY-1];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: record accepts, match pops in order, bound per-requester occupancy.
  always @(posedge clock) begin
    if (!reset) begin
      exp_q0.delete();
      exp_q1.delete();
      outstanding = '{0, 0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (i == 0) exp_q0.push_back(req_data[0] ^ req_key[0]);
          else        exp_q1.push_back(req_data[1] ^ req_key[1]);
          acc_cnt[i]++;
          outstanding[i]++;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          logic [127:0] e;
          if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            check($sformatf("resp_unexpected_%0d", i), 128'd1, 128'd0);
          end else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("resp_data_%0d", i), resp_data[i], e);
          end
          rx_cnt[i]++;
          outstanding[i]--;
        end
        check($sformatf("no_overflow_%0d", i), 128'(outstanding[i] <= OUT_DEPTH), 128'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, lat, seen;
    reset = 1'b0; req_valid = '0; resp_ready = '0; req_data = '0; req_key = '0;
    tick(); tick();
    req_valid = 2'b11;
    #1;
    check("reset_req_ready", 128'(req_ready), 128'd0);
    check("reset_resp_valid", 128'(resp_valid), 128'd0);
    check("reset_pipe_in", pipe_in, 128'd0);
    check("reset_pipe_key", pipe_key, 128'd0);
    req_valid = '0;
    reset = 1'b1;

    // Both requesters valid: grants alternate starting with requester 0.
    resp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      req_valid = 2'b11;
      req_data[0] = {96'h0, 32'hA000_0000 + 32'(k)};
      req_key[0]  = {32'(k), 96'h5};
      req_data[1] = {96'h0, 32'hB000_0000 + 32'(k)};
      req_key[1]  = {32'(k), 96'h7};
      #1;
      check($sformatf("alt_grant_%0d", k), 128'(req_ready), (k % 2 == 0) ? 128'd1 : 128'd2);
      tick();
    end
    req_valid = '0;
    lat = 0;
    while (lat < 60 && !(rx_cnt[0] == 4 && rx_cnt[1] == 4)) begin tick(); lat++; end
    check("alt_rx0", 128'(rx_cnt[0]), 128'd4);
    check("alt_rx1", 128'(rx_cnt[1]), 128'd4);

    // Single request: 12-edge latency and XOR model result.
    req_valid = 2'b01;
    req_data[0] = 128'h00112233445566778899aabbccddeeff;
    req_key[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    #1;
    check("single_ready", 128'(req_ready), 128'd1);
    tick();
    req_valid = '0;
    check("single_pipe_in", pipe_in, 128'h00112233445566778899aabbccddeeff);
    check("single_pipe_key", pipe_key, 128'h000102030405060708090a0b0c0d0e0f);
    lat = 0; seen = 0;
    while (lat < 40) begin
      tick(); lat++;
      if (resp_valid[1]) seen++;
      if (resp_valid[0]) break;
    end
    check("single_latency", 128'(lat), 128'd12);
    check("single_data", resp_data[0], 128'h00102030405060708090a0b0c0d0e0f0);
    check("single_no_resp1", 128'(seen), 128'd0);
    tick();

    // Stalled response side: exactly OUT_DEPTH accepts, then one per freed slot.
    resp_ready = 2'b00;
    req_valid = 2'b01;
    a0 = acc_cnt[0];
    repeat (10) tick();
    check("credit_accepts", 128'(acc_cnt[0] - a0), 128'd4);
    check("credit_ready_low", 128'(req_ready), 128'd0);
    repeat (15) tick();
    check("credit_fifo_full_valid", 128'(resp_valid), 128'd1);
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    a0 = acc_cnt[0];
    repeat (6) tick();
    check("credit_one_more", 128'(acc_cnt[0] - a0), 128'd1);
    req_valid = '0;
    resp_ready = 2'b11;
    repeat (30) tick();
    check("credit_drained0", 128'(outstanding[0]), 128'd0);

    // Requester 0 out of credit: requester 1 takes every grant.
    resp_ready = 2'b00;
    req_valid = 2'b01;
    a0 = acc_cnt[0];
    repeat (5) tick();
    check("exhaust_req0", 128'(acc_cnt[0] - a0), 128'd4);
    resp_ready = 2'b10;
    req_valid = 2'b11;
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    repeat (20) tick();
    check("exhaust_req0_grants", 128'(acc_cnt[0] - a0), 128'd0);
    check("exhaust_req1_grants", 128'(acc_cnt[1] - a1), 128'd8);
    req_valid = '0;
    resp_ready = 2'b11;
    repeat (30) tick();
    check("exhaust_drained0", 128'(outstanding[0]), 128'd0);
    check("exhaust_drained1", 128'(outstanding[1]), 128'd0);

    // Mid-operation reset with five blocks in flight.
    resp_ready = 2'b00;
    req_valid = 2'b11;
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    repeat (5) tick();
    check("flush_inflight", 128'((acc_cnt[0] - a0) + (acc_cnt[1] - a1)), 128'd5);
    reset = 1'b0;
    #1;
    check("flush_ready_gated", 128'(req_ready), 128'd0);
    tick();
    reset = 1'b1;
    req_valid = '0;
    check("flush_pipe_in", pipe_in, 128'd0);
    seen = 0;
    repeat (LATENCY + 2) begin
      tick();
      if (resp_valid != '0) seen++;
    end
    check("flush_quiet", 128'(seen), 128'd0);
    req_valid = 2'b01;
    req_data[0] = 128'hdeadbeef_00000000_cafef00d_12345678;
    a0 = acc_cnt[0];
    repeat (8) tick();
    check("flush_credit_restored", 128'(acc_cnt[0] - a0), 128'd4);
    req_valid = '0;
    resp_ready = 2'b11;
    repeat (25) tick();
    check("flush_drained0", 128'(outstanding[0]), 128'd0);

`ifdef AES_ARB_STATS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("stats_reset_issue", 128'(issue_count), 128'd0);
    check("stats_reset_stall", 128'(stall_count), 128'd0);
    resp_ready = 2'b00;
    req_valid = 2'b10;
    repeat (7) tick();
    req_valid = '0;
    resp_ready = 2'b10;
    repeat (20) tick();
    req_valid = 2'b10;
    repeat (4) tick();
    req_valid = '0;
    repeat (20) tick();
    req_valid = 2'b10;
    repeat (2) tick();
    req_valid = '0;
    tick();
    check("stats_issue1", 128'(issue_count[1]), 128'd10);
    check("stats_stall1", 128'(stall_count[1]), 128'd3);
    check("stats_issue0", 128'(issue_count[0]), 128'd0);
    repeat (20) tick();
`endif

    check("final_q0_empty", 128'(exp_q0.size()), 128'd0);
    check("final_q1_empty", 128'(exp_q1.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
